// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generator: next-PC source encoding, FSM states,
// and the redirect-request decode used by both the generator and its pending buffer.
package pc_gen_pkg;

   localparam logic [1:0] SEL_SEQ  = 2'b00;
   localparam logic [1:0] SEL_BR   = 2'b01;
   localparam logic [1:0] SEL_JMP  = 2'b10;
   localparam logic [1:0] SEL_TRAP = 2'b11;

   typedef enum logic [1:0] {BUBBLE, RUN, HOLD} state_t;

   // A branch only redirects when its qualifier is set; otherwise it is sequential.
   function automatic logic is_redirect(input logic [1:0] sel, input logic branch_check);
      return (sel == SEL_JMP) || (sel == SEL_TRAP) || ((sel == SEL_BR) && branch_check);
   endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect buffer; a trap is never displaced by a branch/jump.
// win_target is combinational: the target that would be held after this cycle's write.
module pc_redirect_buf
   import pc_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            wr_en,
   input  logic [1:0]      wr_sel,
   input  logic [XLEN-1:0] wr_target,
   output logic [XLEN-1:0] win_target
);

   logic            vld_q, vld_d;
   logic [1:0]      sel_q, sel_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            take;

   always_comb begin
      take       = wr_en && (!vld_q || (wr_sel == SEL_TRAP) || (sel_q != SEL_TRAP));
      win_target = take ? wr_target : tgt_q;
      vld_d      = vld_q;
      sel_d      = sel_q;
      tgt_d      = tgt_q;
      if (clr) begin
         vld_d = 1'b0;
         sel_d = SEL_SEQ;
         tgt_d = '0;
      end else if (take) begin
         vld_d = 1'b1;
         sel_d = wr_sel;
         tgt_d = wr_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         sel_q <= SEL_SEQ;
         tgt_q <= '0;
      end else begin
         vld_q <= vld_d;
         sel_q <= sel_d;
         tgt_q <= tgt_d;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential/branch/jump/trap selection, stall buffering, 1-cycle redirect.
// Optional PC_MISALIGN_CHECK_EN rejects unaligned targets and reports them via misalign_exc.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
   parameter int              PC_INC    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      sel,
   input  logic            branch_check,
   input  logic [XLEN-1:0] br_target,
   input  logic [XLEN-1:0] jmp_target,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic            flush,
`ifdef PC_MISALIGN_CHECK_EN
   output logic            misalign_exc,
   output logic [XLEN-1:0] misalign_addr,
`endif
   output logic            redirect_pend
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            flush_q, flush_d;
   logic            raw_req, req_vld, buf_wr, buf_clr;
   logic [XLEN-1:0] tgt_raw, tgt, win_target;

   always_comb begin
      unique case (sel)
         SEL_BR:   tgt_raw = br_target;
         SEL_JMP:  tgt_raw = jmp_target;
         SEL_TRAP: tgt_raw = trap_vec;
         default:  tgt_raw = '0;
      endcase
   end

   assign raw_req = is_redirect(sel, branch_check);

`ifdef PC_MISALIGN_CHECK_EN
   logic            misalign_exc_q, misalign_exc_d;
   logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

   assign req_vld = raw_req && (tgt_raw[1:0] == 2'b00);
   assign tgt     = tgt_raw;

   always_comb begin
      misalign_exc_d  = raw_req && (tgt_raw[1:0] != 2'b00);
      misalign_addr_d = misalign_exc_d ? tgt_raw : misalign_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_exc_q  <= 1'b0;
         misalign_addr_q <= '0;
      end else begin
         misalign_exc_q  <= misalign_exc_d;
         misalign_addr_q <= misalign_addr_d;
      end
   end

   assign misalign_exc  = misalign_exc_q;
   assign misalign_addr = misalign_addr_q;
`else
   assign req_vld = raw_req;
   assign tgt     = tgt_raw & {{(XLEN-2){1'b1}}, 2'b00};
`endif

   pc_redirect_buf #(.XLEN(XLEN)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .clr        (buf_clr),
      .wr_en      (buf_wr),
      .wr_sel     (sel),
      .wr_target  (tgt),
      .win_target (win_target)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      buf_wr  = 1'b0;
      buf_clr = 1'b0;
      unique case (state_q)
         BUBBLE: begin
            buf_wr  = req_vld;
            state_d = req_vld ? HOLD : RUN;
         end
         RUN: begin
            if (fetch_ready) begin
               flush_d = req_vld;
               pc_d    = req_vld ? tgt : pc_q + XLEN'(PC_INC);
            end else if (req_vld) begin
               buf_wr  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // A same-cycle request competes with the buffered one before it is applied.
            buf_wr = req_vld;
            if (fetch_ready) begin
               pc_d    = win_target;
               flush_d = 1'b1;
               buf_clr = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = BUBBLE;
      endcase
      pc_valid_d = (state_d != BUBBLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BUBBLE;
         pc_q       <= RESET_VEC;
         pc_valid_q <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         flush_q    <= flush_d;
      end
   end

   assign pc            = pc_q;
   assign pc_valid      = pc_valid_q;
   assign flush         = flush_q;
   assign redirect_pend = (state_q == HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected outputs are queued with each stimulus and
// compared one cycle later, after the clock edge that consumes that stimulus.
module tb_pc_gen;
   import pc_gen_pkg::*;

   typedef struct packed {
      logic        rst;
      logic [1:0]  sel;
      logic        bc;
      logic        fr;
      logic [31:0] tgt;
   } stim_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        v;
      logic        f;
      logic        p;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  sel = SEL_SEQ;
   logic        branch_check = 1'b0;
   logic [31:0] br_target = '0, jmp_target = '0, trap_vec = '0;
   logic        fetch_ready = 1'b1;
   logic [31:0] pc;
   logic        pc_valid, flush, redirect_pend;
`ifdef PC_MISALIGN_CHECK_EN
   logic        misalign_exc;
   logic [31:0] misalign_addr;
`endif

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk           (clk),
      .rst           (rst),
      .sel           (sel),
      .branch_check  (branch_check),
      .br_target     (br_target),
      .jmp_target    (jmp_target),
      .trap_vec      (trap_vec),
      .fetch_ready   (fetch_ready),
      .pc            (pc),
      .pc_valid      (pc_valid),
      .flush         (flush),
`ifdef PC_MISALIGN_CHECK_EN
      .misalign_exc  (misalign_exc),
      .misalign_addr (misalign_addr),
`endif
      .redirect_pend (redirect_pend)
   );

   task automatic drive(input stim_t s);
      rst          = s.rst;
      sel          = s.sel;
      branch_check = s.bc;
      fetch_ready  = s.fr;
      br_target    = s.tgt;
      jmp_target   = s.tgt;
      trap_vec     = s.tgt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t st[$];
      obs_t  got, want;
      st.push_back({1'b1, SEL_SEQ, 1'b0, 1'b1, 32'h0}); exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
      st.push_back({1'b1, SEL_SEQ, 1'b0, 1'b1, 32'h0}); exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0}); exp_q.push_back({32'h0, 1'b1, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0}); exp_q.push_back({32'h4, 1'b1, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0}); exp_q.push_back({32'h8, 1'b1, 1'b0, 1'b0});
      foreach (st[i]) begin
         drive(st[i]); tick();
         got  = {pc, pc_valid, flush, redirect_pend};
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset step %0d: got pc=%h v=%b f=%b p=%b, want pc=%h v=%b f=%b p=%b",
                     i, got.pc, got.v, got.f, got.p, want.pc, want.v, want.f, want.p);
         end
      end
   endtask

   task automatic test_branch();
      stim_t st[$];
      obs_t  got, want;
      st.push_back({1'b0, SEL_JMP, 1'b0, 1'b1, 32'h100}); exp_q.push_back({32'h100, 1'b1, 1'b1, 1'b0});
      st.push_back({1'b0, SEL_BR,  1'b0, 1'b1, 32'h200}); exp_q.push_back({32'h104, 1'b1, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_BR,  1'b1, 1'b1, 32'h200}); exp_q.push_back({32'h200, 1'b1, 1'b1, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0});   exp_q.push_back({32'h204, 1'b1, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b0, 32'h0});   exp_q.push_back({32'h204, 1'b1, 1'b0, 1'b0});
      foreach (st[i]) begin
         drive(st[i]); tick();
         got  = {pc, pc_valid, flush, redirect_pend};
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL branch step %0d: got pc=%h v=%b f=%b p=%b, want pc=%h v=%b f=%b p=%b",
                     i, got.pc, got.v, got.f, got.p, want.pc, want.v, want.f, want.p);
         end
      end
   endtask

   task automatic test_hold_priority();
      stim_t st[$];
      obs_t  got, want;
      st.push_back({1'b0, SEL_JMP,  1'b0, 1'b1, 32'h40});   exp_q.push_back({32'h40,   1'b1, 1'b1, 1'b0});
      st.push_back({1'b0, SEL_JMP,  1'b0, 1'b0, 32'h80});   exp_q.push_back({32'h40,   1'b1, 1'b0, 1'b1});
      st.push_back({1'b0, SEL_TRAP, 1'b0, 1'b0, 32'h1000}); exp_q.push_back({32'h40,   1'b1, 1'b0, 1'b1});
      st.push_back({1'b0, SEL_JMP,  1'b0, 1'b0, 32'h90});   exp_q.push_back({32'h40,   1'b1, 1'b0, 1'b1});
      st.push_back({1'b0, SEL_SEQ,  1'b0, 1'b1, 32'h0});    exp_q.push_back({32'h1000, 1'b1, 1'b1, 1'b0});
      st.push_back({1'b0, SEL_SEQ,  1'b0, 1'b1, 32'h0});    exp_q.push_back({32'h1004, 1'b1, 1'b0, 1'b0});
      foreach (st[i]) begin
         drive(st[i]); tick();
         got  = {pc, pc_valid, flush, redirect_pend};
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL hold_priority step %0d: got pc=%h v=%b f=%b p=%b, want pc=%h v=%b f=%b p=%b",
                     i, got.pc, got.v, got.f, got.p, want.pc, want.v, want.f, want.p);
         end
      end
   endtask

   task automatic test_hold_merge();
      stim_t st[$];
      obs_t  got, want;
      st.push_back({1'b0, SEL_JMP,  1'b0, 1'b0, 32'h300});  exp_q.push_back({32'h1004, 1'b1, 1'b0, 1'b1});
      st.push_back({1'b0, SEL_BR,   1'b1, 1'b1, 32'h500});  exp_q.push_back({32'h500,  1'b1, 1'b1, 1'b0});
      st.push_back({1'b0, SEL_TRAP, 1'b0, 1'b0, 32'h2000}); exp_q.push_back({32'h500,  1'b1, 1'b0, 1'b1});
      st.push_back({1'b0, SEL_JMP,  1'b0, 1'b1, 32'h600});  exp_q.push_back({32'h2000, 1'b1, 1'b1, 1'b0});
      foreach (st[i]) begin
         drive(st[i]); tick();
         got  = {pc, pc_valid, flush, redirect_pend};
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL hold_merge step %0d: got pc=%h v=%b f=%b p=%b, want pc=%h v=%b f=%b p=%b",
                     i, got.pc, got.v, got.f, got.p, want.pc, want.v, want.f, want.p);
         end
      end
   endtask

   task automatic test_wrap();
      stim_t st[$];
      obs_t  got, want;
      st.push_back({1'b0, SEL_JMP, 1'b0, 1'b1, 32'hFFFF_FFFC}); exp_q.push_back({32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0});         exp_q.push_back({32'h0,         1'b1, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0});         exp_q.push_back({32'h4,         1'b1, 1'b0, 1'b0});
      foreach (st[i]) begin
         drive(st[i]); tick();
         got  = {pc, pc_valid, flush, redirect_pend};
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL wrap step %0d: got pc=%h v=%b f=%b p=%b, want pc=%h v=%b f=%b p=%b",
                     i, got.pc, got.v, got.f, got.p, want.pc, want.v, want.f, want.p);
         end
      end
   endtask

   task automatic test_reset_in_hold();
      stim_t st[$];
      obs_t  got, want;
      st.push_back({1'b0, SEL_JMP, 1'b0, 1'b0, 32'h300}); exp_q.push_back({32'h4, 1'b1, 1'b0, 1'b1});
      st.push_back({1'b1, SEL_JMP, 1'b0, 1'b1, 32'h300}); exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0});   exp_q.push_back({32'h0, 1'b1, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0});   exp_q.push_back({32'h4, 1'b1, 1'b0, 1'b0});
      foreach (st[i]) begin
         drive(st[i]); tick();
         got  = {pc, pc_valid, flush, redirect_pend};
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset_in_hold step %0d: got pc=%h v=%b f=%b p=%b, want pc=%h v=%b f=%b p=%b",
                     i, got.pc, got.v, got.f, got.p, want.pc, want.v, want.f, want.p);
         end
      end
   endtask

   task automatic test_bubble_redirect();
      stim_t st[$];
      obs_t  got, want;
      st.push_back({1'b1, SEL_SEQ,  1'b0, 1'b1, 32'h0});   exp_q.push_back({32'h0,   1'b0, 1'b0, 1'b0});
      st.push_back({1'b0, SEL_TRAP, 1'b0, 1'b0, 32'h800}); exp_q.push_back({32'h0,   1'b1, 1'b0, 1'b1});
      st.push_back({1'b0, SEL_SEQ,  1'b0, 1'b1, 32'h0});   exp_q.push_back({32'h800, 1'b1, 1'b1, 1'b0});
      foreach (st[i]) begin
         drive(st[i]); tick();
         got  = {pc, pc_valid, flush, redirect_pend};
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL bubble_redirect step %0d: got pc=%h v=%b f=%b p=%b, want pc=%h v=%b f=%b p=%b",
                     i, got.pc, got.v, got.f, got.p, want.pc, want.v, want.f, want.p);
         end
      end
   endtask

   task automatic test_misalign();
      stim_t st[$];
      obs_t  got, want;
      st.push_back({1'b0, SEL_JMP, 1'b0, 1'b1, 32'h10});  exp_q.push_back({32'h10,  1'b1, 1'b1, 1'b0});
      st.push_back({1'b0, SEL_JMP, 1'b0, 1'b1, 32'h102});
`ifdef PC_MISALIGN_CHECK_EN
      exp_q.push_back({32'h14, 1'b1, 1'b0, 1'b0});
`else
      exp_q.push_back({32'h100, 1'b1, 1'b1, 1'b0});
`endif
      st.push_back({1'b0, SEL_SEQ, 1'b0, 1'b1, 32'h0});
`ifdef PC_MISALIGN_CHECK_EN
      exp_q.push_back({32'h18, 1'b1, 1'b0, 1'b0});
`else
      exp_q.push_back({32'h104, 1'b1, 1'b0, 1'b0});
`endif
      foreach (st[i]) begin
         drive(st[i]); tick();
         got  = {pc, pc_valid, flush, redirect_pend};
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL misalign step %0d: got pc=%h v=%b f=%b p=%b, want pc=%h v=%b f=%b p=%b",
                     i, got.pc, got.v, got.f, got.p, want.pc, want.v, want.f, want.p);
         end
`ifdef PC_MISALIGN_CHECK_EN
         n_checks++;
         if (misalign_exc !== (i == 1)) begin
            n_fail++;
            $display("FAIL misalign_exc step %0d: got %b want %b", i, misalign_exc, (i == 1));
         end
         if (i == 1) begin
            n_checks++;
            if (misalign_addr !== 32'h102) begin
               n_fail++;
               $display("FAIL misalign_addr: got %h want %h", misalign_addr, 32'h102);
            end
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_hold_priority();
      test_hold_merge();
      test_wrap();
      test_reset_in_hold();
      test_bubble_redirect();
      test_misalign();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
